// File: rtl/lynxTypes.sv
// Shared RDMA metadata layout constants for the aclk-side request/ack paths.
package lynxTypes;

    localparam int RDMA_QPN_BITS     = 16;
    localparam int RDMA_SQ_QPN_LSB   = 0;
    localparam int RDMA_ACK_QPN_LSB  = 0;
    localparam int RDMA_ACK_NACK_BIT = 16;
    localparam int RDMA_SQ_BITS      = 256;
    localparam int RDMA_ACK_BITS     = 40;

endpackage

// File: rtl/rdma_credit_table.sv
// Per-QP outstanding-request counters with limit compare, underflow detect and running total.
module rdma_credit_table #(
    parameter int N_QP    = 16,
    parameter int MAX_OUT = 8
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    inc_en,
    input  logic [$clog2(N_QP)-1:0] inc_qp,
    input  logic                    dec_en,
    input  logic [$clog2(N_QP)-1:0] dec_qp,
    input  logic [$clog2(N_QP)-1:0] chk_qp,
    output logic                    at_limit,
    output logic                    underflow,
    output logic [15:0]             total
);

    localparam int QW = $clog2(N_QP);
    localparam logic [7:0] LIMIT = MAX_OUT[7:0];

    logic [7:0] cnt [N_QP];
    logic       dec_ok;

    // An ack for an empty QP is reported but never takes the count below zero.
    assign underflow = dec_en && (cnt[dec_qp] == 8'd0);
    assign dec_ok    = dec_en && (cnt[dec_qp] != 8'd0);
    assign at_limit  = (cnt[chk_qp] >= LIMIT);

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_QP; i++) begin
                cnt[i] <= 8'd0;
            end
            total <= 16'd0;
        end else begin
            for (int i = 0; i < N_QP; i++) begin
                if (inc_en && (inc_qp == QW'(i)) && !(dec_ok && (dec_qp == QW'(i)))) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end else if (dec_ok && (dec_qp == QW'(i)) && !(inc_en && (inc_qp == QW'(i)))) begin
                    cnt[i] <= cnt[i] - 8'd1;
                end
            end
            case ({inc_en, dec_ok})
                2'b10:   total <= total + 16'd1;
                2'b01:   total <= total - 16'd1;
                default: total <= total;
            endcase
        end
    end

endmodule

// File: rtl/rdma_sq_credit.sv
// Per-QP outstanding-request limiter between the user send queue and the sq crossing.
// Optional statistics counters are built when RDMA_SQ_CREDIT_STATS_EN is defined.
module rdma_sq_credit
    import lynxTypes::*;
#(
    parameter int N_QP    = 16,
    parameter int MAX_OUT = 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_rdma_sq_valid,
    output logic                     s_rdma_sq_ready,
    input  logic [RDMA_SQ_BITS-1:0]  s_rdma_sq_data,
    output logic                     m_rdma_sq_valid,
    input  logic                     m_rdma_sq_ready,
    output logic [RDMA_SQ_BITS-1:0]  m_rdma_sq_data,
    input  logic                     s_rdma_ack_valid,
    output logic                     s_rdma_ack_ready,
    input  logic [RDMA_ACK_BITS-1:0] s_rdma_ack_data,
    output logic                     m_rdma_ack_valid,
    input  logic                     m_rdma_ack_ready,
    output logic [RDMA_ACK_BITS-1:0] m_rdma_ack_data,
    output logic [15:0]              outstanding_total,
    output logic                     underflow_err
`ifdef RDMA_SQ_CREDIT_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [15:0]              nack_count
`endif
);

    localparam int QP_BITS = $clog2(N_QP);

    logic [QP_BITS-1:0] sq_qp;
    logic [QP_BITS-1:0] ack_qp;
    logic               at_limit;
    logic               underflow;
    logic               sq_hs;
    logic               ack_hs;

    assign sq_qp  = s_rdma_sq_data[RDMA_SQ_QPN_LSB +: QP_BITS];
    assign ack_qp = s_rdma_ack_data[RDMA_ACK_QPN_LSB +: QP_BITS];

    // Ready depends only on registered counts, so a returned credit is usable the next cycle.
    assign s_rdma_sq_ready  = (!m_rdma_sq_valid || m_rdma_sq_ready) && !at_limit;
    assign s_rdma_ack_ready = !m_rdma_ack_valid || m_rdma_ack_ready;
    assign sq_hs            = s_rdma_sq_valid && s_rdma_sq_ready;
    assign ack_hs           = s_rdma_ack_valid && s_rdma_ack_ready;

    rdma_credit_table #(
        .N_QP    (N_QP),
        .MAX_OUT (MAX_OUT)
    ) u_table (
        .aclk      (aclk),
        .areset    (areset),
        .inc_en    (sq_hs),
        .inc_qp    (sq_qp),
        .dec_en    (ack_hs),
        .dec_qp    (ack_qp),
        .chk_qp    (sq_qp),
        .at_limit  (at_limit),
        .underflow (underflow),
        .total     (outstanding_total)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_rdma_sq_valid <= 1'b0;
        end else if (sq_hs) begin
            m_rdma_sq_valid <= 1'b1;
            m_rdma_sq_data  <= s_rdma_sq_data;
        end else if (m_rdma_sq_ready) begin
            m_rdma_sq_valid <= 1'b0;
        end
    end

    // Acks, nacks and underflowing acks alike are forwarded untouched.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_rdma_ack_valid <= 1'b0;
        end else if (ack_hs) begin
            m_rdma_ack_valid <= 1'b1;
            m_rdma_ack_data  <= s_rdma_ack_data;
        end else if (m_rdma_ack_ready) begin
            m_rdma_ack_valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            underflow_err <= 1'b0;
        end else if (underflow) begin
            underflow_err <= 1'b1;
        end
    end

`ifdef RDMA_SQ_CREDIT_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            stall_cycles <= 32'd0;
            nack_count   <= 16'd0;
        end else begin
            if (s_rdma_sq_valid && at_limit && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (m_rdma_ack_valid && m_rdma_ack_ready && m_rdma_ack_data[RDMA_ACK_NACK_BIT]) begin
                nack_count <= nack_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rdma_sq_credit.sv
// Randomized self-checking bench for rdma_sq_credit against a queue-based reference model.
module tb_rdma_sq_credit;
    import lynxTypes::*;

    localparam int N_QP    = 16;
    localparam int MAX_OUT = 8;

    logic                     aclk;
    logic                     areset;
    logic                     s_rdma_sq_valid;
    logic                     s_rdma_sq_ready;
    logic [RDMA_SQ_BITS-1:0]  s_rdma_sq_data;
    logic                     m_rdma_sq_valid;
    logic                     m_rdma_sq_ready;
    logic [RDMA_SQ_BITS-1:0]  m_rdma_sq_data;
    logic                     s_rdma_ack_valid;
    logic                     s_rdma_ack_ready;
    logic [RDMA_ACK_BITS-1:0] s_rdma_ack_data;
    logic                     m_rdma_ack_valid;
    logic                     m_rdma_ack_ready;
    logic [RDMA_ACK_BITS-1:0] m_rdma_ack_data;
    logic [15:0]              outstanding_total;
    logic                     underflow_err;
`ifdef RDMA_SQ_CREDIT_STATS_EN
    logic [31:0]              stall_cycles;
    logic [15:0]              nack_count;
`endif

    rdma_sq_credit #(
        .N_QP    (N_QP),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_rdma_sq_valid   (s_rdma_sq_valid),
        .s_rdma_sq_ready   (s_rdma_sq_ready),
        .s_rdma_sq_data    (s_rdma_sq_data),
        .m_rdma_sq_valid   (m_rdma_sq_valid),
        .m_rdma_sq_ready   (m_rdma_sq_ready),
        .m_rdma_sq_data    (m_rdma_sq_data),
        .s_rdma_ack_valid  (s_rdma_ack_valid),
        .s_rdma_ack_ready  (s_rdma_ack_ready),
        .s_rdma_ack_data   (s_rdma_ack_data),
        .m_rdma_ack_valid  (m_rdma_ack_valid),
        .m_rdma_ack_ready  (m_rdma_ack_ready),
        .m_rdma_ack_data   (m_rdma_ack_data),
        .outstanding_total (outstanding_total),
        .underflow_err     (underflow_err)
`ifdef RDMA_SQ_CREDIT_STATS_EN
        ,
        .stall_cycles      (stall_cycles),
        .nack_count        (nack_count)
`endif
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Reference model: outstanding count per QP, sticky error, and in-order output queues.
    int                       modelCnt [N_QP];
    bit                       modelErr;
    logic [RDMA_SQ_BITS-1:0]  sqQueue  [$];
    logic [RDMA_ACK_BITS-1:0] ackQueue [$];
    int                       modelStall;
    int                       modelNack;

    int checksRun;
    int checksPassed;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checksRun++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int modelTotal();
        int sum = 0;
        for (int i = 0; i < N_QP; i++) sum += modelCnt[i];
        return sum;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < N_QP; i++) modelCnt[i] = 0;
        modelErr   = 1'b0;
        sqQueue.delete();
        ackQueue.delete();
        modelStall = 0;
        modelNack  = 0;
    endfunction

    task automatic checkState();
        checkOutput("sq_valid", 256'(m_rdma_sq_valid), 256'(sqQueue.size() != 0));
        if (sqQueue.size() != 0) checkOutput("sq_data", m_rdma_sq_data, sqQueue[0]);
        checkOutput("ack_valid", 256'(m_rdma_ack_valid), 256'(ackQueue.size() != 0));
        if (ackQueue.size() != 0) checkOutput("ack_data", 256'(m_rdma_ack_data), 256'(ackQueue[0]));
        checkOutput("total", 256'(outstanding_total), 256'(modelTotal()));
        checkOutput("underflow_err", 256'(underflow_err), 256'(modelErr));
`ifdef RDMA_SQ_CREDIT_STATS_EN
        checkOutput("stall_cycles", 256'(stall_cycles), 256'(modelStall));
        checkOutput("nack_count", 256'(nack_count), 256'(modelNack[15:0]));
`endif
    endtask

    task automatic doReset();
        @(negedge aclk);
        areset           = 1'b1;
        s_rdma_sq_valid  = 1'b0;
        s_rdma_ack_valid = 1'b0;
        m_rdma_sq_ready  = 1'b0;
        m_rdma_ack_ready = 1'b0;
        @(posedge aclk);
        #1;
        modelReset();
        checkState();
    endtask

    // One clock cycle: drive inputs, check readies, advance model, check registered outputs.
    task automatic applyStimulus(input bit sqValid, input logic [RDMA_SQ_BITS-1:0] sqData, input bit sqOutReady,
                                 input bit ackValid, input logic [RDMA_ACK_BITS-1:0] ackData, input bit ackOutReady);
        int  sqQp;
        int  ackQp;
        bit  expSqReady;
        bit  expAckReady;
        bit  sqHs;
        bit  ackHs;
        bit  sqPop;
        bit  ackPop;
        @(negedge aclk);
        areset           = 1'b0;
        s_rdma_sq_valid  = sqValid;
        s_rdma_sq_data   = sqData;
        m_rdma_sq_ready  = sqOutReady;
        s_rdma_ack_valid = ackValid;
        s_rdma_ack_data  = ackData;
        m_rdma_ack_ready = ackOutReady;
        #1;
        sqQp        = int'(sqData[3:0]);
        ackQp       = int'(ackData[3:0]);
        expSqReady  = (sqQueue.size() == 0 || sqOutReady) && (modelCnt[sqQp] < MAX_OUT);
        expAckReady = (ackQueue.size() == 0) || ackOutReady;
        checkOutput("sq_ready", 256'(s_rdma_sq_ready), 256'(expSqReady));
        checkOutput("ack_ready", 256'(s_rdma_ack_ready), 256'(expAckReady));
        sqHs   = sqValid && expSqReady;
        ackHs  = ackValid && expAckReady;
        sqPop  = (sqQueue.size() != 0) && sqOutReady;
        ackPop = (ackQueue.size() != 0) && ackOutReady;
        @(posedge aclk);
        if (sqValid && modelCnt[sqQp] >= MAX_OUT) modelStall++;
        if (ackPop && ackQueue[0][RDMA_ACK_NACK_BIT]) modelNack++;
        if (sqPop) void'(sqQueue.pop_front());
        if (ackPop) void'(ackQueue.pop_front());
        if (ackHs) begin
            if (modelCnt[ackQp] == 0) modelErr = 1'b1;
            else modelCnt[ackQp]--;
            ackQueue.push_back(ackData);
        end
        if (sqHs) begin
            modelCnt[sqQp]++;
            sqQueue.push_back(sqData);
        end
        #1;
        checkState();
    endtask

    function automatic logic [RDMA_SQ_BITS-1:0] makeSq(input int qp);
        logic [RDMA_SQ_BITS-1:0] d;
        for (int w = 0; w < RDMA_SQ_BITS / 32; w++) d[w*32 +: 32] = $urandom;
        d[3:0] = 4'(qp);
        return d;
    endfunction

    function automatic logic [RDMA_ACK_BITS-1:0] makeAck(input int qp, input bit nack);
        logic [RDMA_ACK_BITS-1:0] d;
        d[31:0]  = $urandom;
        d[39:32] = 8'($urandom);
        d[3:0]   = 4'(qp);
        d[RDMA_ACK_NACK_BIT] = nack;
        return d;
    endfunction

    initial begin
        checksRun    = 0;
        checksPassed = 0;
        areset       = 1'b1;
        s_rdma_sq_data  = '0;
        s_rdma_ack_data = '0;
        doReset();

        applyStimulus(1'b1, makeSq(3), 1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        for (int k = 0; k < 10; k++) applyStimulus(1'b1, makeSq(5), 1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, makeSq(5), 1'b1, 1'b1, makeAck(5, 1'b1), 1'b1);
        applyStimulus(1'b1, makeSq(5), 1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, makeSq(6), 1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, makeSq(6), 1'b1, 1'b1, makeAck(5, 1'b0), 1'b1);
        applyStimulus(1'b1, makeSq(6), 1'b1, 1'b0, '0, 1'b1);

        for (int k = 0; k < 4; k++) applyStimulus(1'b1, makeSq(2), 1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, makeSq(2), 1'b1, 1'b1, makeAck(2, 1'b0), 1'b1);

        applyStimulus(1'b0, '0, 1'b1, 1'b1, makeAck(7, 1'b0), 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        applyStimulus(1'b0, '0, 1'b1, 1'b1, makeAck(3, 1'b1), 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, makeAck(5, 1'b0), 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, 1'b1, 1'b1, makeAck(5, 1'b0), 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

        for (int pass = 0; pass < 2; pass++) begin
            doReset();
            for (int cyc = 0; cyc < 1500; cyc++) begin
                int  sq_q;
                int  ack_q;
                sq_q  = int'($urandom_range(0, 3));
                ack_q = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
                applyStimulus($urandom_range(0, 9) < 7, makeSq(sq_q), $urandom_range(0, 3) != 0,
                              $urandom_range(0, 9) < 4, makeAck(ack_q, 1'($urandom)), $urandom_range(0, 3) != 0);
            end
        end

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
